// File: rtl/ooop_types.sv
// ooop_types: shared types for the out-of-order pipeline front end.
//   N_PHYS_REGS  - physical register file size
//   PREG_W       - physical register index width
//   ROB_TAG_W    - reorder buffer tag width
//   rename_pkt_t - one renamed instruction as handed from rename to dispatch
package ooop_types;

  localparam int N_PHYS_REGS = 64;
  localparam int PREG_W      = $clog2(N_PHYS_REGS);
  localparam int ROB_TAG_W   = 5;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [PREG_W-1:0]    prd;
    logic [PREG_W-1:0]    prs1;
    logic                 prs1_ready;
    logic                 rs1_used;
    logic [PREG_W-1:0]    prs2;
    logic                 prs2_ready;
    logic                 rs2_used;
    logic                 is_load;
    logic                 is_store;
    logic                 is_branch;
    logic                 is_jump;
    logic [3:0]           alu_op;
  } rename_pkt_t;

endpackage

// File: rtl/dispatch_stage_if.sv
// dispatch_stage_if: rename -> dispatch valid/ready handshake.
//   valid_in  - rename presents a packet
//   ready_out - dispatch can take a packet this cycle
//   pkt_in    - the renamed instruction
// master = rename side, slave = dispatch side.
interface dispatch_stage_if;

  logic                    valid_in;
  logic                    ready_out;
  ooop_types::rename_pkt_t pkt_in;

  modport master (output valid_in, output pkt_in, input ready_out);
  modport slave  (input valid_in, input pkt_in, output ready_out);

endinterface

// File: rtl/dispatch_stage.sv
// dispatch_stage: consumer end of the rename -> dispatch handshake.
// Buffers renamed packets in a small in-order skid FIFO, allocates a ROB
// entry for the head packet and writes it into the ALU, LSU or BRU
// reservation station once both the ROB and that station have room.
// Writeback broadcasts are snooped so buffered source-ready bits stay current.
//
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   flush_i                  - drop every buffered packet
//   rn                       - rename handshake (valid_in / ready_out / pkt_in)
//   wb_valid_i, wb_preg_i    - writeback broadcast
//   rob_ready_i              - ROB has a free entry
//   rob_alloc_o, rob_pkt_o   - ROB allocate strobe and packet
//   alu/lsu/bru_valid_o      - RS write strobes (one-hot on dispatch)
//   alu/lsu/bru_ready_i      - RS has space
//   rs_pkt_o                 - packet to the selected RS, ready bits updated
//   stall_cnt_o              - saturating count of cycles the head was held
module dispatch_stage #(
  parameter int DEPTH       = 2,
  parameter int N_PHYS_REGS = ooop_types::N_PHYS_REGS,
  parameter int CNT_W       = 32,
  localparam int PREG_W     = $clog2(N_PHYS_REGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  dispatch_stage_if.slave         rn,
  input  logic                    wb_valid_i,
  input  logic [PREG_W-1:0]       wb_preg_i,
  input  logic                    rob_ready_i,
  output logic                    rob_alloc_o,
  output ooop_types::rename_pkt_t rob_pkt_o,
  output logic                    alu_valid_o,
  input  logic                    alu_ready_i,
  output logic                    lsu_valid_o,
  input  logic                    lsu_ready_i,
  output logic                    bru_valid_o,
  input  logic                    bru_ready_i,
  output ooop_types::rename_pkt_t rs_pkt_o,
  output logic [CNT_W-1:0]        stall_cnt_o
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

  ooop_types::rename_pkt_t mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [PTR_W:0]          count;

  ooop_types::rename_pkt_t head_pkt;
  logic head_valid, to_lsu, to_bru, to_alu, tgt_ready, push, pop;
  logic wb_en;

  // Set source-ready bits matching the broadcast register; bits are never
  // cleared, and preg 0 never takes part in a match.
  function automatic ooop_types::rename_pkt_t wake(
    input ooop_types::rename_pkt_t p,
    input logic                    en,
    input logic [PREG_W-1:0]       preg
  );
    ooop_types::rename_pkt_t r;
    r = p;
    if (en) begin
      if (p.rs1_used && p.prs1 == preg) r.prs1_ready = 1'b1;
      if (p.rs2_used && p.prs2 == preg) r.prs2_ready = 1'b1;
    end
    return r;
  endfunction

  assign wb_en        = wb_valid_i && (wb_preg_i != '0);
  assign head_valid   = (count != '0);
  // Full-ness comes straight from the count register, so rename never sees
  // a combinational path from any downstream ready.
  assign rn.ready_out = (count != FULL_CNT);
  assign push         = rn.valid_in && rn.ready_out && !flush_i;

  // Same-cycle writeback is forwarded onto the head before it leaves.
  assign head_pkt = wake(mem[rd_ptr], wb_en, wb_preg_i);

  always_comb begin
    // NOTE: every signal gets a default before the branches so no path
    // leaves it unassigned and no latch is inferred.
    to_lsu    = 1'b0;
    to_bru    = 1'b0;
    to_alu    = 1'b0;
    tgt_ready = 1'b0;
    if (head_pkt.is_load || head_pkt.is_store) begin
      to_lsu    = 1'b1;
      tgt_ready = lsu_ready_i;
    end else if (head_pkt.is_branch || head_pkt.is_jump) begin
      to_bru    = 1'b1;
      tgt_ready = bru_ready_i;
    end else begin
      to_alu    = 1'b1;
      tgt_ready = alu_ready_i;
    end
  end

  // ROB and RS must both have room; there is never a partial dispatch.
  assign pop = head_valid && rob_ready_i && tgt_ready && !flush_i;

  assign rob_alloc_o = pop;
  assign alu_valid_o = pop && to_alu;
  assign lsu_valid_o = pop && to_lsu;
  assign bru_valid_o = pop && to_bru;
  assign rob_pkt_o   = pop ? head_pkt : '0;
  assign rs_pkt_o    = pop ? head_pkt : '0;

  // NOTE: storage has no reset; an entry is only meaningful while count
  // covers it, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] <= wake(mem[i], wb_en, wb_preg_i);
    end
    // A newly pushed packet also sees this cycle's broadcast; it overrides
    // the snoop update above for the tail slot, which is free on a push.
    if (push) mem[wr_ptr] <= wake(rn.pkt_in, wb_en, wb_preg_i);
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (head_valid && !pop && stall_cnt_o != '1) begin
          stall_cnt_o <= stall_cnt_o + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/dispatch_stage.md
Name: dispatch_stage

Overview:
- Consumer end of the rename→dispatch valid/ready interface.
- Accepts ooop_types::rename_pkt_t packets into a 2-entry in-order skid FIFO.
- Allocates the ROB entry for each packet and steers it to the ALU, LSU or BRU reservation station.
- Snoops the writeback bus so buffered source-ready bits never go stale. Feeds ROB/RS; backpressures rename.

Parameters:
- DEPTH, 2, skid FIFO entries (power of two, ≥2).
- N_PHYS_REGS, ooop_types::N_PHYS_REGS, physical register count; PREG_W = $clog2(N_PHYS_REGS).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush_i  input  1  drop all buffered packets.
- valid_in  input  1  rename packet valid.
- ready_out  output  1  dispatch can accept a packet.
- pkt_in  input  rename_pkt_t  renamed instruction.
- wb_valid_i  input  1  writeback broadcast valid.
- wb_preg_i  input  PREG_W  physical register written back.
- rob_ready_i  input  1  ROB has a free entry.
- rob_alloc_o  output  1  ROB allocate strobe.
- rob_pkt_o  output  rename_pkt_t  packet written to ROB.
- alu_valid_o  output  1  ALU RS write.
- alu_ready_i  input  1  ALU RS has space.
- lsu_valid_o  output  1  LSU RS write.
- lsu_ready_i  input  1  LSU RS has space.
- bru_valid_o  output  1  BRU RS write.
- bru_ready_i  input  1  BRU RS has space.
- rs_pkt_o  output  rename_pkt_t  packet to the selected RS, with ready bits updated.
- stall_cnt_o  output  CNT_W  count of cycles where the head is valid but not dispatched.

Behaviour:
- Reset (rst_n=0, asynchronous): FIFO empty, pointers/count=0, stall_cnt_o=0. All valid outputs are 0. rob_pkt_o/rs_pkt_o='0. ready_out=1 once reset is released.
- ready_out = (count != DEPTH). It depends only on registered state; there is no combinational path from any downstream ready.
- Push: valid_in && ready_out. The packet is written at the tail on the clock edge. Latency from accept to earliest dispatch is 1 cycle. No bypass from pkt_in to the outputs.
- Routing of the head packet:
  - is_load|is_store → LSU.
  - else is_branch|is_jump → BRU.
  - else → ALU.
- tgt_ready = ready of the selected RS.
- Pop: head valid && rob_ready_i && tgt_ready && !flush_i. In a pop cycle:
  - rob_alloc_o=1.
  - exactly one of alu/lsu/bru_valid_o=1.
  - rob_pkt_o = rs_pkt_o = head packet.
- Outside a pop cycle all strobes are 0. Both ROB and RS space are required; a partial dispatch never occurs.
- Wakeup snoop, every cycle while wb_valid_i && wb_preg_i != 0:
  - Stored entries: set prs1_ready if rs1_used && prs1==wb_preg_i; same rule for prs2.
  - A packet being pushed in the same cycle is also updated before storage.
  - Output forward: the ready bits in rs_pkt_o/rob_pkt_o include a same-cycle wb match.
  - preg 0 is always ready and is never cleared.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.
- Full FIFO: ready_out=0. A push is never accepted; a pop frees a slot for the next cycle only.
- Empty FIFO: no strobes asserted, and the stall counter does not increment.
- flush_i (priority over everything): on the next edge count=0 and pointers reset. A push presented in the same cycle is discarded. No strobes are asserted in the flush cycle. stall_cnt_o is not cleared.
- stall_cnt_o: +1 when the head is valid, !flush_i and no pop occurs. Saturates at all-ones.
- Buffered ready bits are only ever set, never cleared.
- Reset mid-operation: immediate return to the reset state; in-flight packets are lost.

Test Plan:
- Single ALU add, all readies=1: push at cycle 0 → cycle 1 rob_alloc_o=1, alu_valid_o=1, lsu/bru=0; FIFO empty at cycle 2; stall_cnt_o=0.
- Load, store, branch, jal pushed back-to-back: strobes are lsu, lsu, bru, bru on consecutive cycles. rob_pkt_o.rob_tag matches push order.
- Backpressure: lsu_ready_i=0, push 3 loads → the third is refused (ready_out=0 after 2 accepts). Raising lsu_ready_i drains 1/cycle, and ready_out rises the cycle after the first pop. stall_cnt_o equals the number of held cycles.
- Wakeup: buffered packet with prs1=5, prs1_ready=0, rob_ready_i=0. Pulse wb_valid_i with wb_preg_i=5, then release rob_ready_i → rs_pkt_o.prs1_ready=1. Repeat with the wb pulse in the dispatch cycle itself → still 1. wb_preg_i=0 causes no change.
- Flush with 2 entries and a simultaneous push: the next cycle count=0, ready_out=1, and no strobes fire afterwards.
- Async reset asserted mid-cycle with a full FIFO: outputs are 0 immediately (before the clock edge), and stall_cnt_o=0.
